trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/riscv_pkg.sv | 64 ++++++
 rtl/int_prio_enc.sv | 29 ++
 rtl/trap_ctrl.sv | 109 ++++++++++
 tb/tb_trap_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V trap definitions: interrupt/exception codes, trap FSM states, interrupt priority order.
// Optional macro TRAP_CTRL_SMODE_EN lets the supervisor interrupts (SEI/SSI/STI) take part in selection.
package riscv_pkg;

    typedef enum logic [4:0] {
        IRQ_SSI = 5'd1,
        IRQ_MSI = 5'd3,
        IRQ_STI = 5'd5,
        IRQ_MTI = 5'd7,
        IRQ_SEI = 5'd9,
        IRQ_MEI = 5'd11,
        IRQ_COI = 5'd13
    } int_code_e;

    typedef enum logic [4:0] {
        EXC_INSN_MISALIGN = 5'd0,
        EXC_INSN_FAULT    = 5'd1,
        EXC_ILLEGAL_INSN  = 5'd2,
        EXC_BREAKPOINT    = 5'd3,
        EXC_LOAD_MISALIGN = 5'd4,
        EXC_LOAD_FAULT    = 5'd5,
        EXC_STORE_MISALIGN= 5'd6,
        EXC_STORE_FAULT   = 5'd7,
        EXC_ECALL_U       = 5'd8,
        EXC_ECALL_S       = 5'd9,
        EXC_ECALL_M       = 5'd11,
        EXC_INSN_PAGE     = 5'd12,
        EXC_LOAD_PAGE     = 5'd13,
        EXC_STORE_PAGE    = 5'd15
    } exc_code_e;

    typedef enum logic [1:0] {
        TRAP_IDLE   = 2'd0,
        TRAP_FLUSH  = 2'd1,
        TRAP_COMMIT = 2'd2
    } trap_ctrl_state_e;

    // Highest priority first.
    localparam int unsigned INT_PRIO_NUM = 7;
    localparam int_code_e INT_PRIO [INT_PRIO_NUM] = '{
        IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI, IRQ_COI
    };

    function automatic logic int_code_enabled(input int_code_e c);
`ifdef TRAP_CTRL_SMODE_EN
        return 1'b1;
`else
        return !(c inside {IRQ_SEI, IRQ_SSI, IRQ_STI});
`endif
    endfunction

    // Bit set for every interrupt code that may ever be selected in this build.
    function automatic logic [31:0] int_code_mask();
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < INT_PRIO_NUM; i++) begin
            if (int_code_enabled(INT_PRIO[i])) begin
                m[INT_PRIO[i]] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority interrupt encoder: picks the highest-priority pending code from an already-masked vector.
// NUM_IRQ must not exceed 32.
module int_prio_enc
    import riscv_pkg::*;
#(
    parameter int NUM_IRQ = 16
) (
    input  logic [NUM_IRQ-1:0] pend_i,
    output logic               valid_o,
    output logic [4:0]         code_o
);

    logic [31:0] pend_ext;

    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_IRQ-1:0] = pend_i;
        valid_o = 1'b0;
        code_o  = '0;
        // Walk the list in priority order; the first hit sticks.
        for (int unsigned i = 0; i < INT_PRIO_NUM; i++) begin
            if (!valid_o && pend_ext[INT_PRIO[i]]) begin
                valid_o = 1'b1;
                code_o  = INT_PRIO[i];
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates interrupts vs. synchronous exceptions, flushes the pipeline, commits the trap.
// Optional macro TRAP_CTRL_SMODE_EN (see riscv_pkg) enables supervisor interrupts.
module trap_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] mip_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic               gie_i,
    input  logic               exc_valid_i,
    input  logic [4:0]         exc_code_i,
    input  logic [XLEN-1:0]    exc_pc_i,
    input  logic [XLEN-1:0]    exc_tval_i,
    input  logic [XLEN-1:0]    cur_pc_i,
    output logic               flush_o,
    input  logic               flush_ack_i,
    output logic               trap_valid_o,
    input  logic               trap_ready_i,
    output logic               trap_is_int_o,
    output logic [4:0]         trap_code_o,
    output logic [XLEN-1:0]    trap_epc_o,
    output logic [XLEN-1:0]    trap_tval_o,
    output logic               busy_o
);

    localparam logic [31:0] INT_MASK = int_code_mask();

    trap_ctrl_state_e  state_q, state_d;
    logic              is_int_q, is_int_d;
    logic [4:0]        code_q, code_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   tval_q, tval_d;

    logic [NUM_IRQ-1:0] irq_pend;
    logic               irq_valid;
    logic [4:0]         irq_code;

    assign irq_pend = mip_i & mie_i & INT_MASK[NUM_IRQ-1:0];

    int_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_int_prio_enc (
        .pend_i  (irq_pend),
        .valid_o (irq_valid),
        .code_o  (irq_code)
    );

    always_comb begin
        state_d  = state_q;
        is_int_d = is_int_q;
        code_d   = code_q;
        epc_d    = epc_q;
        tval_d   = tval_q;
        unique case (state_q)
            TRAP_IDLE: begin
                // A coincident exception is dropped; its instruction replays after the flush.
                if (gie_i && irq_valid) begin
                    is_int_d = 1'b1;
                    code_d   = irq_code;
                    epc_d    = cur_pc_i;
                    tval_d   = '0;
                    state_d  = TRAP_FLUSH;
                end else if (exc_valid_i) begin
                    is_int_d = 1'b0;
                    code_d   = exc_code_i;
                    epc_d    = exc_pc_i;
                    tval_d   = exc_tval_i;
                    state_d  = TRAP_FLUSH;
                end
            end
            TRAP_FLUSH: begin
                if (flush_ack_i) state_d = TRAP_COMMIT;
            end
            TRAP_COMMIT: begin
                if (trap_ready_i) state_d = TRAP_IDLE;
            end
            default: state_d = TRAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TRAP_IDLE;
            is_int_q <= 1'b0;
            code_q   <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
        end else begin
            state_q  <= state_d;
            is_int_q <= is_int_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
        end
    end

    assign flush_o       = (state_q == TRAP_FLUSH);
    assign trap_valid_o  = (state_q == TRAP_COMMIT);
    assign busy_o        = (state_q != TRAP_IDLE);
    assign trap_is_int_o = is_int_q;
    assign trap_code_o   = code_q;
    assign trap_epc_o    = epc_q;
    assign trap_tval_o   = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized events against a transaction-level model.
module tb_trap_ctrl;

    localparam int XLEN    = 32;
    localparam int NUM_IRQ = 16;
`ifdef TRAP_CTRL_SMODE_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] mip_i, mie_i;
    logic               gie_i, exc_valid_i;
    logic [4:0]         exc_code_i;
    logic [XLEN-1:0]    exc_pc_i, exc_tval_i, cur_pc_i;
    logic               flush_o, flush_ack_i, trap_valid_o, trap_ready_i;
    logic               trap_is_int_o;
    logic [4:0]         trap_code_o;
    logic [XLEN-1:0]    trap_epc_o, trap_tval_o;
    logic               busy_o;

    int compared   = 0;
    int mismatched = 0;

    trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mip_i         (mip_i),
        .mie_i         (mie_i),
        .gie_i         (gie_i),
        .exc_valid_i   (exc_valid_i),
        .exc_code_i    (exc_code_i),
        .exc_pc_i      (exc_pc_i),
        .exc_tval_i    (exc_tval_i),
        .cur_pc_i      (cur_pc_i),
        .flush_o       (flush_o),
        .flush_ack_i   (flush_ack_i),
        .trap_valid_o  (trap_valid_o),
        .trap_ready_i  (trap_ready_i),
        .trap_is_int_o (trap_is_int_o),
        .trap_code_o   (trap_code_o),
        .trap_epc_o    (trap_epc_o),
        .trap_tval_o   (trap_tval_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the architectural priority list over the enabled pending set.
    function automatic bit model_irq(input logic [NUM_IRQ-1:0] mip, input logic [NUM_IRQ-1:0] mie,
                                     input logic gie, output logic [4:0] code);
        int prio [7] = '{11, 3, 7, 9, 1, 5, 13};
        logic [NUM_IRQ-1:0] p = mip & mie;
        code = '0;
        if (!gie) return 1'b0;
        foreach (prio[k]) begin
            if (!SMODE && (prio[k] == 9 || prio[k] == 1 || prio[k] == 5)) continue;
            if (p[prio[k]]) begin
                code = 5'(prio[k]);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic quiet();
        gie_i       = 1'b0;
        exc_valid_i = 1'b0;
        mip_i       = '0;
        mie_i       = '0;
    endtask

    task automatic check_outs(input string tag, input logic is_int, input logic [4:0] code,
                              input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval);
        check({tag, ".is_int"}, 64'(trap_is_int_o), 64'(is_int));
        check({tag, ".code"},   64'(trap_code_o),   64'(code));
        check({tag, ".epc"},    64'(trap_epc_o),    64'(epc));
        check({tag, ".tval"},   64'(trap_tval_o),   64'(tval));
    endtask

    // Presents one event in IDLE, then walks the flush and commit handshakes with
    // fw cycles of flush_ack low and rw cycles of trap_ready low.
    task automatic run_event(input string tag, input logic [NUM_IRQ-1:0] mip, input logic [NUM_IRQ-1:0] mie,
                             input logic gie, input logic ev, input logic [4:0] ec,
                             input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval,
                             input logic [XLEN-1:0] cur, input int fw, input int rw);
        logic            fire, is_int;
        logic [4:0]      code;
        logic [XLEN-1:0] xepc, xtval;
        if (model_irq(mip, mie, gie, code)) begin
            fire = 1'b1; is_int = 1'b1; xepc = cur; xtval = '0;
        end else if (ev) begin
            fire = 1'b1; is_int = 1'b0; code = ec; xepc = epc; xtval = tval;
        end else begin
            fire = 1'b0; is_int = 1'b0; xepc = '0; xtval = '0;
        end
        mip_i = mip; mie_i = mie; gie_i = gie;
        exc_valid_i = ev; exc_code_i = ec; exc_pc_i = epc; exc_tval_i = tval; cur_pc_i = cur;
        flush_ack_i  = 1'($urandom);
        trap_ready_i = 1'($urandom);
        check({tag, ".idle_busy"}, 64'(busy_o), 64'(0));
        cyc();
        if (!fire) begin
            check({tag, ".no_trap_busy"},  64'(busy_o),       64'(0));
            check({tag, ".no_trap_flush"}, 64'(flush_o),      64'(0));
            check({tag, ".no_trap_valid"}, 64'(trap_valid_o), 64'(0));
            quiet();
            return;
        end
        for (int i = 0; i <= fw; i++) begin
            check({tag, ".flush_o"},     64'(flush_o),      64'(1));
            check({tag, ".flush_valid"}, 64'(trap_valid_o), 64'(0));
            check({tag, ".flush_busy"},  64'(busy_o),       64'(1));
            check_outs({tag, ".flush"}, is_int, code, xepc, xtval);
            mip_i = NUM_IRQ'($urandom); mie_i = NUM_IRQ'($urandom);
            gie_i = 1'($urandom); exc_valid_i = 1'($urandom);
            cur_pc_i = $urandom; exc_pc_i = $urandom; exc_tval_i = $urandom; exc_code_i = 5'($urandom);
            trap_ready_i = 1'b1;
            flush_ack_i  = (i == fw);
            cyc();
        end
        for (int j = 0; j <= rw; j++) begin
            check({tag, ".commit_valid"}, 64'(trap_valid_o), 64'(1));
            check({tag, ".commit_flush"}, 64'(flush_o),      64'(0));
            check({tag, ".commit_busy"},  64'(busy_o),       64'(1));
            check_outs({tag, ".commit"}, is_int, code, xepc, xtval);
            mip_i = NUM_IRQ'($urandom); mie_i = NUM_IRQ'($urandom);
            gie_i = 1'($urandom); exc_valid_i = 1'($urandom);
            flush_ack_i  = 1'($urandom);
            trap_ready_i = (j == rw);
            if (j == rw) quiet();
            cyc();
        end
        check({tag, ".done_valid"}, 64'(trap_valid_o), 64'(0));
        check({tag, ".done_busy"},  64'(busy_o),       64'(0));
        check({tag, ".done_flush"}, 64'(flush_o),      64'(0));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".flush"}, 64'(flush_o),      64'(0));
        check({tag, ".valid"}, 64'(trap_valid_o), 64'(0));
        check({tag, ".busy"},  64'(busy_o),       64'(0));
        check_outs(tag, 1'b0, 5'd0, '0, '0);
    endtask

    // Drives an exception into FLUSH (to_commit=0) or COMMIT (to_commit=1), then resets mid-trap.
    task automatic reset_mid_trap(input string tag, input bit to_commit);
        quiet();
        exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h2000; exc_tval_i = 32'h55;
        flush_ack_i = 1'b0; trap_ready_i = 1'b0;
        cyc();
        exc_valid_i = 1'b0;
        check({tag, ".pre_flush"}, 64'(flush_o), 64'(1));
        if (to_commit) begin
            flush_ack_i = 1'b1;
            cyc();
            flush_ack_i = 1'b0;
            check({tag, ".pre_commit"}, 64'(trap_valid_o), 64'(1));
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outs({tag, ".async"});
        cyc();
        trap_ready_i = 1'b1;
        flush_ack_i  = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        check_reset_outs({tag, ".after"});
        trap_ready_i = 1'b0;
        flush_ack_i  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        exc_code_i = '0; exc_pc_i = '0; exc_tval_i = '0; cur_pc_i = '0;
        flush_ack_i = 1'b0; trap_ready_i = 1'b0;
        #1 check_reset_outs("reset0");
        cyc();
        cyc();
        check_reset_outs("reset1");
        rst_n = 1'b1;
        cyc();

        // MEI beats MSI/MTI, two-cycle latency with acks high.
        run_event("mei_lat", 16'h0888, 16'h0888, 1'b1, 1'b0, 5'd0, '0, '0, 32'h400, 0, 0);
        // Mixed machine and supervisor pendings.
        run_event("smode_mix", 16'h02A2, 16'h02A2, 1'b1, 1'b0, 5'd0, '0, '0, 32'h404, 0, 0);
        // Only supervisor pendings: traps only when S-mode is enabled.
        run_event("smode_only", 16'h0222, 16'h0222, 1'b1, 1'b0, 5'd0, '0, '0, 32'h408, 0, 0);
        // Interrupt wins over a coincident exception.
        run_event("irq_vs_exc", 16'h0080, 16'h0080, 1'b1, 1'b1, 5'd2, 32'h100, 32'hDEAD, 32'h104, 0, 0);
        // Long flush and commit stalls.
        run_event("stall", '0, '0, 1'b0, 1'b1, 5'd13, 32'h300, 32'hBEEF, 32'h304, 5, 3);
        // Global enable low blocks, then raising it traps.
        run_event("gie_low", 16'h0800, 16'h0800, 1'b0, 1'b0, 5'd0, '0, '0, 32'h500, 0, 0);
        run_event("gie_high", 16'h0800, 16'h0800, 1'b1, 1'b0, 5'd0, '0, '0, 32'h500, 0, 0);
        // Pending but not enabled, and unlisted codes only.
        run_event("not_en", 16'h0800, 16'h0000, 1'b1, 1'b0, 5'd0, '0, '0, 32'h600, 0, 0);
        run_event("unlisted", 16'hD555, 16'hD555, 1'b1, 1'b0, 5'd0, '0, '0, 32'h604, 0, 0);
        run_event("coi", 16'h2000, 16'h2000, 1'b1, 1'b0, 5'd0, '0, '0, 32'h608, 1, 1);

        reset_mid_trap("rst_commit", 1'b1);
        reset_mid_trap("rst_flush", 1'b0);

        for (int n = 0; n < 60; n++) begin
            run_event("rand",
                      NUM_IRQ'($urandom & $urandom), NUM_IRQ'($urandom),
                      1'($urandom), 1'($urandom), 5'($urandom),
                      $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
